// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input for (a - b) mode.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [WIDTH-1:0]  res_sr_q, res_sr_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic              fa_sum;
    logic              fa_carry;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;
    logic [WIDTH-1:0]  res_next;

    // Subtraction is a + ~b + 1; cin is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_carry = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    assign res_next = {fa_sum, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                res_sr_d = res_next;
                carry_d  = fa_carry;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    sum_d   = res_next;
                    cout_d  = fa_carry;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); honours SERIAL_ADDER_SUB_EN.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic         vsub;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, scramble inputs afterwards, and check timing and result.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input logic [W-1:0] es,
                          input logic ec, input int poke_at);
        logic [W-1:0] held;
        int           n;
        bit           stable;
        held  = sum;
        a     = ta;
        b     = tb_v;
        cin   = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = ts;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
        cin   = ~tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = ~ts;
`endif
        n      = 0;
        stable = 1'b1;
        while (busy === 1'b1 && n < int'(W) + 4) begin
            if (n == poke_at) begin
                start = 1'b1;
                a     = 8'h55;
                b     = 8'hAA;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
            if (sum !== held || done !== 1'b0) stable = 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        chk({name, " busy_cycles"}, n, W);
        chk({name, " no_partial"}, {31'd0, stable}, 32'd1);
        chk({name, " done"}, {31'd0, done}, 32'd1);
        chk({name, " sum"}, {24'd0, sum}, {24'd0, es});
        chk({name, " cout"}, {31'd0, cout}, {31'd0, ec});
        tick();
        chk({name, " done_pulse_len"}, {31'd0, done}, 32'd0);
        chk({name, " idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1) cnt++;
            tick();
        end
    endtask

    initial begin
        int           cnt;
        int           t0;
        int           t1;
        int           cyc;
        logic [W-1:0] s0;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        vecs.push_back('{"add_0f_01",    8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0});
        vecs.push_back('{"add_ff_01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{"add_00_00_c1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{"add_80_80",    8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"add_aa_55",    8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{"add_7f_01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
        vecs.push_back('{"add_3c_c3_c1", 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{"sub_05_07",    8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{"sub_07_05",    8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{"sub_09_09",    8'h09, 8'h09, 1'b0, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{"add_sub0",     8'h05, 8'h07, 1'b1, 1'b0, 8'h0D, 1'b0});
`endif

        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset sum", {24'd0, sum}, 32'd0);
        chk("reset cout", {31'd0, cout}, 32'd0);

        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) cyc++;
            tick();
        end
        chk("idle hold", cyc, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                   vecs[i].esum, vecs[i].ecout, -1);
        end

        // Start re-pulsed during SHIFT must be ignored.
        run_op("restart_ignored", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 2);
        count_dones(2 * W, cnt);
        chk("restart single_done", cnt, 0);
        chk("restart still_idle", {31'd0, busy}, 32'd0);

        // Reset in the 4th SHIFT cycle aborts without a done pulse.
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort sum", {24'd0, sum}, 32'd0);
        chk("abort cout", {31'd0, cout}, 32'd0);
        count_dones(2 * W, cnt);
        chk("abort no_done", cnt, 0);

        run_op("after_abort", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, -1);

        // rst and start on the same edge: request lost.
        s0    = sum;
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_start busy", {31'd0, busy}, 32'd0);
        chk("rst_start sum_cleared", {24'd0, sum}, 32'd0);
        count_dones(2 * W, cnt);
        chk("rst_start no_done", cnt, 0);
        chk("rst_start prev_nonzero", {24'd0, s0}, 32'h47);

        // Start held high: accepts every W+2 cycles.
        a     = 8'h21;
        b     = 8'h12;
        cin   = 1'b0;
        start = 1'b1;
        t0    = -1;
        t1    = -1;
        for (int i = 0; i < 4 * int'(W); i++) begin
            if (done === 1'b1) begin
                if (t0 < 0) t0 = i;
                else if (t1 < 0) t1 = i;
            end
            tick();
        end
        start = 1'b0;
        chk("held first_done", {31'd0, (t0 >= 0)}, 32'd1);
        chk("held period", t1 - t0, W + 2);
        chk("held sum", {24'd0, sum}, 32'h33);
        count_dones(2 * W, cnt);
        chk("held stops", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
